// File: rtl/cache_arbiter_if.sv
// Bundle between the arbiter, the two caches and physical memory.
// Latency: none (wires only).
// Backpressure: cache requests are levels held until resp; memory paces beats with pmem_resp.
// Ports:
//   icache  : i_read, i_address -> i_rdata, i_resp
//   dcache  : d_read, d_write, d_address, d_wdata -> d_rdata, d_resp
//   pmem    : pmem_read, pmem_write, pmem_address, pmem_wdata <- pmem_rdata, pmem_resp
// master is the arbiter's view; slave is the caches/memory view.
interface cache_arbiter_if;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;

    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;

    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    modport master (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport slave (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/cache_arbiter.sv
// Arbitrates icache/dcache line transfers onto one 4x64-bit burst memory port.
// Latency: grant the cycle after the request, 4 beats, one DONE cycle carrying resp.
// Backpressure: memory stalls each beat by withholding pmem_resp; requests are ignored outside IDLE.
// Ports: clk, rst (sync, active-high), bus (cache_arbiter_if.master).
module cache_arbiter (
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   cnt;
    logic [31:0]  addr_q;
    logic [255:0] wdata_q;
    logic [255:0] line_q;
    // Remembers whose transaction is finishing so DONE can steer the resp pulse.
    logic         owner_i;

    logic         d_req;
    logic         any_req;
    logic [31:0]  grant_addr;
    logic [7:0]   beat_ofs;
    logic         in_burst;

    // Line-offset bits of the request addresses are deliberately discarded.
    logic         unused_addr_bits;
    assign unused_addr_bits = ^{bus.i_address[4:0], bus.d_address[4:0]};

    assign d_req      = bus.d_read | bus.d_write;
    assign any_req    = d_req | bus.i_read;
    assign grant_addr = d_req ? bus.d_address : bus.i_address;
    assign beat_ofs   = {cnt, 6'b0};
    assign in_burst   = (state == I_RD) || (state == D_RD) || (state == D_WR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 256'd0;
            line_q  <= 256'd0;
            owner_i <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        addr_q  <= {grant_addr[31:5], 5'b0};
                        wdata_q <= bus.d_wdata;
                        cnt     <= 2'd0;
                        owner_i <= ~d_req;
                    end
                end
                I_RD, D_RD: begin
                    if (bus.pmem_resp) begin
                        line_q[beat_ofs +: 64] <= bus.pmem_rdata;
                        cnt <= cnt + 2'd1;
                    end
                end
                D_WR: begin
                    if (bus.pmem_resp) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // Write wins over read when the dcache raises both.
                if (bus.d_write)     state_nxt = D_WR;
                else if (bus.d_read) state_nxt = D_RD;
                else if (bus.i_read) state_nxt = I_RD;
            end
            I_RD, D_RD, D_WR: begin
                if (bus.pmem_resp && (cnt == 2'd3)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.pmem_read    = (state == I_RD) || (state == D_RD);
    assign bus.pmem_write   = (state == D_WR);
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q[beat_ofs +: 64];

    assign bus.i_resp  = (state == DONE) && owner_i;
    assign bus.d_resp  = (state == DONE) && !owner_i;
    assign bus.i_rdata = line_q;
    assign bus.d_rdata = line_q;

    // Unused-but-intentional: in_burst documents the burst states for readers of waveforms.
    logic unused_in_burst;
    assign unused_in_burst = in_burst;
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: stimulus changes and sampling both happen on the falling edge.
// Latency: n/a.
// Backpressure: memory beats are hand-paced by each scenario task.
module tb_cache_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    cache_arbiter_if bus ();

    cache_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_read     = 1'b0;
        bus.i_address  = 32'd0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_address  = 32'd0;
        bus.d_wdata    = 256'd0;
        bus.pmem_rdata = 64'd0;
        bus.pmem_resp  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read got=%b want=0", bus.pmem_read); end
        checks++; if (bus.pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write got=%b want=0", bus.pmem_write); end
        checks++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin errors++; $display("FAIL reset_resp got=%b want=00", {bus.i_resp, bus.d_resp}); end
        checks++; if (bus.pmem_address !== 32'd0) begin errors++; $display("FAIL reset_addr got=%h want=0", bus.pmem_address); end
        checks++; if (bus.i_rdata !== 256'd0 || bus.d_rdata !== 256'd0) begin errors++; $display("FAIL reset_rdata got=%h want=0", bus.i_rdata); end
        rst = 1'b0;
        step();
        checks++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b%b want=00", bus.pmem_read, bus.pmem_write); end
    endtask

    // Icache line fill, 4 back-to-back beats.
    task automatic test_icache_read();
        logic [63:0]  beats [4];
        logic [255:0] exp;
        beats[0] = 64'h1111_1111_1111_1111;
        beats[1] = 64'h2222_2222_2222_2222;
        beats[2] = 64'h3333_3333_3333_3333;
        beats[3] = 64'h4444_4444_4444_4444;
        exp = {beats[3], beats[2], beats[1], beats[0]};
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_1234;
        step();
        for (int b = 0; b < 4; b++) begin
            checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0) begin errors++; $display("FAIL iread_rd_beat%0d got=%b%b want=10", b, bus.pmem_read, bus.pmem_write); end
            checks++; if (bus.pmem_address !== 32'h0000_1220) begin errors++; $display("FAIL iread_addr_beat%0d got=%h want=00001220", b, bus.pmem_address); end
            checks++; if (bus.i_resp !== 1'b0) begin errors++; $display("FAIL iread_early_resp beat%0d got=%b want=0", b, bus.i_resp); end
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = beats[b];
            step();
        end
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 64'd0;
        checks++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0) begin errors++; $display("FAIL iread_resp got i=%b d=%b want i=1 d=0", bus.i_resp, bus.d_resp); end
        checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL iread_done_rd got=%b want=0", bus.pmem_read); end
        checks++; if (bus.i_rdata !== exp) begin errors++; $display("FAIL iread_rdata got=%h want=%h", bus.i_rdata, exp); end
        bus.i_read = 1'b0;
        step();
        checks++; if (bus.i_resp !== 1'b0) begin errors++; $display("FAIL iread_resp_pulse got=%b want=0", bus.i_resp); end
        checks++; if (bus.i_rdata !== exp) begin errors++; $display("FAIL iread_hold got=%h want=%h", bus.i_rdata, exp); end
    endtask

    // Simultaneous icache and dcache reads: dcache first, then icache.
    task automatic test_priority();
        logic [255:0] exp_d;
        logic [255:0] exp_i;
        exp_d = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002, 64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
        exp_i = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_2000;
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_3047;
        step();
        checks++; if (bus.pmem_address !== 32'h0000_3040) begin errors++; $display("FAIL prio_first_addr got=%h want=00003040", bus.pmem_address); end
        for (int b = 0; b < 4; b++) begin
            checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("FAIL prio_d_rd beat%0d got=%b want=1", b, bus.pmem_read); end
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = exp_d[64*b +: 64];
            step();
        end
        bus.pmem_resp = 1'b0;
        checks++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin errors++; $display("FAIL prio_d_resp got d=%b i=%b want d=1 i=0", bus.d_resp, bus.i_resp); end
        checks++; if (bus.d_rdata !== exp_d) begin errors++; $display("FAIL prio_d_rdata got=%h want=%h", bus.d_rdata, exp_d); end
        bus.d_read = 1'b0;
        step();
        checks++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin errors++; $display("FAIL prio_gap got=%b%b want=00", bus.pmem_read, bus.pmem_write); end
        step();
        checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h0000_2000) begin errors++; $display("FAIL prio_i_grant got rd=%b addr=%h want rd=1 addr=00002000", bus.pmem_read, bus.pmem_address); end
        for (int b = 0; b < 4; b++) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = exp_i[64*b +: 64];
            step();
        end
        bus.pmem_resp = 1'b0;
        checks++; if (bus.i_resp !== 1'b1 || bus.d_resp !== 1'b0) begin errors++; $display("FAIL prio_i_resp got i=%b d=%b want i=1 d=0", bus.i_resp, bus.d_resp); end
        checks++; if (bus.i_rdata !== exp_i) begin errors++; $display("FAIL prio_i_rdata got=%h want=%h", bus.i_rdata, exp_i); end
        bus.i_read = 1'b0;
        step();
    endtask

    // Dcache writeback with two idle cycles ahead of every beat.
    task automatic test_write_gaps(input logic both);
        logic [255:0] wline;
        logic [255:0] held;
        int           resp_cnt;
        wline = {64'hDDDD_DDDD_0000_0004, 64'hCCCC_CCCC_0000_0003, 64'hBBBB_BBBB_0000_0002, 64'hAAAA_AAAA_0000_0001};
        if (both) wline = ~wline;
        held          = bus.d_rdata;
        resp_cnt      = 0;
        bus.d_write   = 1'b1;
        bus.d_read    = both;
        bus.d_address = 32'h4000_001F;
        bus.d_wdata   = wline;
        step();
        // Changing the request data mid-burst must not affect what is written.
        bus.d_wdata = 256'd0;
        checks++; if (bus.pmem_address !== 32'h4000_0000) begin errors++; $display("FAIL wr_addr got=%h want=40000000", bus.pmem_address); end
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < 2; g++) begin
                checks++; if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin errors++; $display("FAIL wr_ctl b%0d g%0d got wr=%b rd=%b want wr=1 rd=0", b, g, bus.pmem_write, bus.pmem_read); end
                checks++; if (bus.pmem_wdata !== wline[64*b +: 64]) begin errors++; $display("FAIL wr_hold b%0d g%0d got=%h want=%h", b, g, bus.pmem_wdata, wline[64*b +: 64]); end
                if (bus.d_resp === 1'b1) resp_cnt++;
                step();
            end
            checks++; if (bus.pmem_wdata !== wline[64*b +: 64]) begin errors++; $display("FAIL wr_beat%0d got=%h want=%h", b, bus.pmem_wdata, wline[64*b +: 64]); end
            bus.pmem_resp = 1'b1;
            step();
            bus.pmem_resp = 1'b0;
        end
        checks++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin errors++; $display("FAIL wr_resp got d=%b i=%b want d=1 i=0", bus.d_resp, bus.i_resp); end
        checks++; if (bus.pmem_write !== 1'b0) begin errors++; $display("FAIL wr_done_wr got=%b want=0", bus.pmem_write); end
        checks++; if (bus.d_rdata !== held) begin errors++; $display("FAIL wr_line_kept got=%h want=%h", bus.d_rdata, held); end
        bus.d_write = 1'b0;
        bus.d_read  = 1'b0;
        step();
        checks++; if (resp_cnt !== 0 || bus.d_resp !== 1'b0) begin errors++; $display("FAIL wr_single_resp extra=%0d now=%b want 0/0", resp_cnt, bus.d_resp); end
    endtask

    // Stray memory responses in IDLE and DONE must leave the line buffer alone.
    task automatic test_stray_resp();
        logic [255:0] held;
        logic [255:0] exp;
        exp = {64'h7777_0000_0000_0003, 64'h6666_0000_0000_0002, 64'h5555_0000_0000_0001, 64'h4444_0000_0000_0000};
        held = bus.d_rdata;
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        step();
        step();
        bus.pmem_resp = 1'b0;
        step();
        checks++; if (bus.d_rdata !== held || bus.pmem_read !== 1'b0) begin errors++; $display("FAIL idle_resp got=%h rd=%b want=%h rd=0", bus.d_rdata, bus.pmem_read, held); end
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_8000;
        step();
        for (int b = 0; b < 4; b++) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = exp[64*b +: 64];
            step();
        end
        // DONE cycle: keep pmem_resp high with junk data.
        bus.pmem_rdata = 64'hBAD1_BAD1_BAD1_BAD1;
        checks++; if (bus.d_resp !== 1'b1) begin errors++; $display("FAIL b2b_resp got=%b want=1", bus.d_resp); end
        bus.d_read = 1'b0;
        step();
        bus.pmem_resp = 1'b0;
        checks++; if (bus.d_rdata !== exp) begin errors++; $display("FAIL done_resp got=%h want=%h", bus.d_rdata, exp); end
        step();
    endtask

    // Reset in the middle of a read, then a clean dcache read.
    task automatic test_reset_midburst();
        logic [255:0] exp;
        int           resp_seen;
        exp = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2, 64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
        resp_seen     = 0;
        bus.i_read    = 1'b1;
        bus.i_address = 32'h0000_5000;
        step();
        for (int b = 0; b < 2; b++) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = 64'hF0F0_0000_0000_0000 | 64'(b);
            step();
        end
        bus.pmem_resp = 1'b0;
        checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("FAIL rst_mid_active got=%b want=1", bus.pmem_read); end
        rst        = 1'b1;
        bus.i_read = 1'b0;
        step();
        checks++; if (bus.pmem_read !== 1'b0 || bus.pmem_address !== 32'd0) begin errors++; $display("FAIL rst_mid_abort got rd=%b addr=%h want rd=0 addr=0", bus.pmem_read, bus.pmem_address); end
        checks++; if (bus.i_rdata !== 256'd0) begin errors++; $display("FAIL rst_mid_line got=%h want=0", bus.i_rdata); end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (bus.i_resp === 1'b1 || bus.d_resp === 1'b1) resp_seen++;
            step();
        end
        checks++; if (resp_seen !== 0) begin errors++; $display("FAIL rst_mid_no_resp got=%0d want=0", resp_seen); end
        bus.d_read    = 1'b1;
        bus.d_address = 32'h0000_6000;
        step();
        for (int b = 0; b < 4; b++) begin
            checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("FAIL rst_new_rd beat%0d got=%b want=1", b, bus.pmem_read); end
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = exp[64*b +: 64];
            step();
        end
        bus.pmem_resp = 1'b0;
        checks++; if (bus.d_resp !== 1'b1 || bus.i_resp !== 1'b0) begin errors++; $display("FAIL rst_new_resp got d=%b i=%b want d=1 i=0", bus.d_resp, bus.i_resp); end
        checks++; if (bus.d_rdata !== exp) begin errors++; $display("FAIL rst_new_rdata got=%h want=%h", bus.d_rdata, exp); end
        bus.d_read = 1'b0;
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_icache_read();
        test_priority();
        test_write_gaps(1'b0);
        test_write_gaps(1'b1);
        test_stray_resp();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameters: none; line size fixed at 256 bits, burst of 4 beats x 64 bits.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 i_read  input  1  icache line-fill request; level, held until i_resp.
REQ-005 i_address  input  32  icache line address.
REQ-006 i_rdata  output  256  line returned to icache.
REQ-007 i_resp  output  1  one-cycle pulse: icache transaction complete.
REQ-008 d_read  input  1  dcache line-fill request; level, held until d_resp.
REQ-009 d_write  input  1  dcache writeback request; level, held until d_resp.
REQ-010 d_address  input  32  dcache line address.
REQ-011 d_wdata  input  256  dcache writeback line.
REQ-012 d_rdata  output  256  line returned to dcache.
REQ-013 d_resp  output  1  one-cycle pulse: dcache transaction complete.
REQ-014 pmem_read  output  1  physical memory burst read; held for the whole burst.
REQ-015 pmem_write  output  1  physical memory burst write; held for the whole burst.
REQ-016 pmem_address  output  32  burst base address, bits [4:0] always 0.
REQ-017 pmem_wdata  output  64  current write beat.
REQ-018 pmem_rdata  input  64  current read beat, valid when pmem_resp=1.
REQ-019 pmem_resp  input  1  one-cycle pulse per beat accepted/returned; beats may be non-consecutive.

Function
REQ-020 States SHALL be IDLE, I_RD, D_RD, D_WR, DONE; a 2-bit beat counter, a 32-bit address register, a 256-bit write register and a 256-bit line buffer SHALL exist.
REQ-021 IDLE: if d_write -> D_WR; else if d_read -> D_RD; else if i_read -> I_RD; else stay. Dcache has fixed priority over icache.
REQ-022 d_read and d_write both high SHALL be treated as write (D_WR).
REQ-023 On leaving IDLE, address register SHALL latch {granted address[31:5], 5'b0}, write register SHALL latch d_wdata, beat counter SHALL clear to 0.
REQ-024 pmem_read SHALL be 1 exactly in I_RD and D_RD; pmem_write exactly in D_WR; never both; pmem_address SHALL equal the address register.
REQ-025 I_RD/D_RD: each cycle pmem_resp=1, line buffer[64*cnt +: 64] <= pmem_rdata and cnt increments; on beat cnt=3 with pmem_resp, next state DONE.
REQ-026 D_WR: pmem_wdata SHALL equal write register[64*cnt +: 64] combinationally; cnt increments on pmem_resp; beat cnt=3 with pmem_resp -> DONE.
REQ-027 DONE SHALL last exactly one cycle, then IDLE; i_resp=1 in DONE only if the transaction was I_RD, d_resp=1 only if D_RD or D_WR.
REQ-028 Requests SHALL NOT be sampled in DONE; the requester drops its request the cycle after resp, so no stale re-grant occurs.
REQ-029 i_rdata and d_rdata SHALL both drive the line buffer; valid during resp and held until the next read burst's first beat.
REQ-030 Requests changing while not in IDLE SHALL be ignored; the granted transaction always completes all 4 beats.
REQ-031 Minimum latency: request in IDLE cycle 0, pmem_read/write from cycle 1, with 4 back-to-back pmem_resp in cycles 1-4, resp in cycle 5.
REQ-032 pmem_resp in IDLE or DONE SHALL be ignored (no counter or buffer change).

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, cnt=0, address, write and line registers=0, at any state including mid-burst.
REQ-034 During and immediately after reset, pmem_read, pmem_write, i_resp, d_resp SHALL be 0, pmem_address=0, i_rdata=d_rdata=0; an aborted burst SHALL produce no resp.

Verification
REQ-035 i_read=1, i_address=0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. back-to-back -> pmem_read cycles 1-4, pmem_address=0x0000_1220, i_resp pulse cycle 5, i_rdata={0x44..,0x33..,0x22..,0x11..}.
REQ-036 i_read and d_read rise same cycle -> D_RD granted first with d_resp, then I_RD after the dcache drops its request; no overlap of bursts.
REQ-037 d_write=1, d_wdata beats A,B,C,D, pmem_resp with 2 idle cycles between beats -> pmem_wdata A,B,C,D in order, each held until its pmem_resp, single d_resp.
REQ-038 d_read and d_write both high -> pmem_write only, pmem_read stays 0.
REQ-039 rst asserted after beat 2 of a read -> next cycle IDLE, pmem_read=0, no i_resp/d_resp; a new request then completes normally with cnt starting at 0.
